// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin select arbiter: requester count,
// select width, FSM state encoding and a wrap-around index helper.
package arb_pkg;

  localparam int unsigned N_REQ = 16;
  localparam int unsigned SEL_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Index of the channel after idx, wrapping from N_REQ-1 back to 0.
  function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] idx);
    return idx + {{(SEL_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: finds the first set request bit scanning
// upward from ptr with wrap-around. Done as rotate, priority-encode, un-rotate.
module rr_pick
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] pick,
  output logic             any
);

  logic [N_REQ-1:0] rot_s;
  logic [SEL_W-1:0] off_s;

  // Rotate the request vector so that bit ptr lands at position 0.
  always_comb begin
    rot_s = {N_REQ{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      rot_s[i] = req[SEL_W'(i) + ptr];
    end
  end

  // Lowest set bit of the rotated vector wins; scanning downward lets it overwrite.
  always_comb begin
    off_s = {SEL_W{1'b0}};
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot_s[i]) begin
        off_s = SEL_W'(i);
      end else begin
        off_s = off_s;
      end
    end
  end

  // Undo the rotation; the 4-bit add wraps modulo N_REQ.
  assign pick = off_s + ptr;
  assign any  = |req;

endmodule

// File: rtl/rr_select_arbiter.sv
// Round-robin arbiter feeding the 4x16 one-hot decoder. Grants one of 16
// requesters, holds its index on select with valid until done, then returns
// to IDLE for at least one cycle. All outputs are registered so the decoder
// sees a glitch-free select.
// Optional feature: define ARB_TIMEOUT_EN to add a hold counter that forces
// a release after MAX_HOLD grant cycles and pulses timeout for one cycle.
module rr_select_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 255,
  parameter int unsigned HOLD_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [SEL_W-1:0] select,
  output logic             valid,
  output logic             timeout
);

  // A hold limit of zero or one that does not fit the counter is a build error.
  if ((MAX_HOLD == 0) || (MAX_HOLD >= (64'd1 << HOLD_W))) begin : g_bad_hold_cfg
    $error("rr_select_arbiter: MAX_HOLD must be in 1 .. 2**HOLD_W-1");
  end

  arb_state_t       state_r, state_nxt_s;
  logic [SEL_W-1:0] ptr_r, ptr_nxt_s;
  logic [SEL_W-1:0] select_r, select_nxt_s;
  logic             valid_r, valid_nxt_s;
  logic             timeout_r, timeout_nxt_s;
  logic [SEL_W-1:0] pick_s;
  logic             any_s;
  logic             force_rel_s;
  logic             release_s;

  rr_pick u_pick (
    .req  (req),
    .ptr  (ptr_r),
    .pick (pick_s),
    .any  (any_s)
  );

`ifdef ARB_TIMEOUT_EN
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  logic [HOLD_W-1:0] hold_cnt_r, hold_cnt_nxt_s;

  // Forced release once the grant has used its full budget without done.
  always_comb begin
    if ((state_r == GRANT) && !done && (hold_cnt_r == HOLD_LAST)) begin
      force_rel_s = 1'b1;
    end else begin
      force_rel_s = 1'b0;
    end
  end

  // Hold counter runs during GRANT and is zero whenever a grant begins.
  always_comb begin
    if ((state_r == GRANT) && !release_s) begin
      hold_cnt_nxt_s = hold_cnt_r + {{(HOLD_W-1){1'b0}}, 1'b1};
    end else begin
      hold_cnt_nxt_s = {HOLD_W{1'b0}};
    end
  end

  // Hold counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt_r <= {HOLD_W{1'b0}};
    end else begin
      hold_cnt_r <= hold_cnt_nxt_s;
    end
  end
`else
  assign force_rel_s = 1'b0;
`endif

  assign release_s = done || force_rel_s;

  // State register; reset overrides every other event.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state: any request starts a grant, a release always passes through IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (any_s) begin
          state_nxt_s = GRANT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      GRANT: begin
        if (release_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = GRANT;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Next values of the registered outputs and the search pointer.
  always_comb begin
    select_nxt_s  = select_r;
    valid_nxt_s   = 1'b0;
    timeout_nxt_s = 1'b0;
    ptr_nxt_s     = ptr_r;
    case (state_r)
      IDLE: begin
        if (any_s) begin
          select_nxt_s = pick_s;
          valid_nxt_s  = 1'b1;
        end else begin
          select_nxt_s = select_r;
          valid_nxt_s  = 1'b0;
        end
      end
      GRANT: begin
        if (release_s) begin
          valid_nxt_s   = 1'b0;
          timeout_nxt_s = force_rel_s;
          ptr_nxt_s     = next_idx(select_r);
        end else begin
          valid_nxt_s   = 1'b1;
          timeout_nxt_s = 1'b0;
          ptr_nxt_s     = ptr_r;
        end
      end
      default: begin
        select_nxt_s  = {SEL_W{1'b0}};
        valid_nxt_s   = 1'b0;
        timeout_nxt_s = 1'b0;
        ptr_nxt_s     = {SEL_W{1'b0}};
      end
    endcase
  end

  // Output and pointer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      select_r  <= {SEL_W{1'b0}};
      valid_r   <= 1'b0;
      timeout_r <= 1'b0;
      ptr_r     <= {SEL_W{1'b0}};
    end else begin
      select_r  <= select_nxt_s;
      valid_r   <= valid_nxt_s;
      timeout_r <= timeout_nxt_s;
      ptr_r     <= ptr_nxt_s;
    end
  end

  assign select  = select_r;
  assign valid   = valid_r;
  assign timeout = timeout_r;

endmodule

// File: tb/tb_rr_select_arbiter.sv
// Self-checking bench for rr_select_arbiter: a table of per-cycle vectors
// plus a hand-written fairness sweep, with expectations queued on drive and
// compared after the clock edge. Built with MAX_HOLD=4 so the timeout
// variant (ARB_TIMEOUT_EN) is exercised in a few cycles.
module tb_rr_select_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] req;
  logic        done;
  logic [3:0]  select;
  logic        valid;
  logic        timeout;

  always #5 clk = ~clk;

  rr_select_arbiter #(.MAX_HOLD(4), .HOLD_W(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .done    (done),
    .select  (select),
    .valid   (valid),
    .timeout (timeout)
  );

  typedef struct {
    logic        r;
    logic [15:0] q;
    logic        d;
    logic        v;
    logic [3:0]  s;
    logic        t;
  } vec_t;

  typedef struct {
    logic       v;
    logic [3:0] s;
    logic       t;
    string      tag;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic add(input logic r, input logic [15:0] q, input logic d,
                     input logic v, input logic [3:0] s, input logic t);
    vec_t x;
    x.r = r; x.q = q; x.d = d; x.v = v; x.s = s; x.t = t;
    vecs.push_back(x);
  endtask

  // Drive one cycle of inputs, queue the expected outputs after the next edge, then compare.
  task automatic step(input logic r, input logic [15:0] q, input logic d,
                      input logic v, input logic [3:0] s, input logic t, input string tag);
    exp_t e;
    @(negedge clk);
    reset = r; req = q; done = d;
    e.v = v; e.s = s; e.t = t; e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    checks++;
    if (valid !== e.v || select !== e.s || timeout !== e.t) begin
      errors++;
      $display("FAIL %s: got valid=%b select=%0d timeout=%b, want valid=%b select=%0d timeout=%b",
               e.tag, valid, select, timeout, e.v, e.s, e.t);
    end
  endtask

  initial begin
    reset = 1'b1;
    req   = 16'h0000;
    done  = 1'b0;

    // reset held two cycles with every requester active
    add(1'b1, 16'hFFFF, 1'b0, 1'b0, 4'd0,  1'b0);
    add(1'b1, 16'hFFFF, 1'b0, 1'b0, 4'd0,  1'b0);
    // single requester, done one cycle after valid
    add(1'b0, 16'h0001, 1'b0, 1'b1, 4'd0,  1'b0);
    add(1'b0, 16'h0001, 1'b1, 1'b0, 4'd0,  1'b0);
    add(1'b0, 16'h0000, 1'b0, 1'b0, 4'd0,  1'b0);
    // done while idle is ignored
    add(1'b0, 16'h0000, 1'b1, 1'b0, 4'd0,  1'b0);
    // alternation 0,15,0,15 from a fresh pointer
    add(1'b1, 16'h8001, 1'b0, 1'b0, 4'd0,  1'b0);
    add(1'b0, 16'h8001, 1'b0, 1'b1, 4'd0,  1'b0);
    add(1'b0, 16'h8001, 1'b1, 1'b0, 4'd0,  1'b0);
    add(1'b0, 16'h8001, 1'b0, 1'b1, 4'd15, 1'b0);
    add(1'b0, 16'h8001, 1'b1, 1'b0, 4'd15, 1'b0);
    add(1'b0, 16'h8001, 1'b0, 1'b1, 4'd0,  1'b0);
    add(1'b0, 16'h8001, 1'b1, 1'b0, 4'd0,  1'b0);
    add(1'b0, 16'h8001, 1'b0, 1'b1, 4'd15, 1'b0);
    add(1'b0, 16'h8001, 1'b1, 1'b0, 4'd15, 1'b0);
    // pointer wrapped to 0 after 15
    add(1'b0, 16'h0003, 1'b0, 1'b1, 4'd0,  1'b0);
    add(1'b0, 16'h0003, 1'b1, 1'b0, 4'd0,  1'b0);
    add(1'b0, 16'h0003, 1'b0, 1'b1, 4'd1,  1'b0);
    // dropping the request does not end the grant
    add(1'b0, 16'h0000, 1'b0, 1'b1, 4'd1,  1'b0);
    add(1'b0, 16'h0000, 1'b1, 1'b0, 4'd1,  1'b0);
    // search from 2 wraps round to 0
    add(1'b0, 16'h0003, 1'b0, 1'b1, 4'd0,  1'b0);
    add(1'b0, 16'h0003, 1'b1, 1'b0, 4'd0,  1'b0);
    // reset mid-grant on channel 9
    add(1'b0, 16'h0201, 1'b0, 1'b1, 4'd9,  1'b0);
    add(1'b0, 16'h0201, 1'b0, 1'b1, 4'd9,  1'b0);
    add(1'b1, 16'h0201, 1'b0, 1'b0, 4'd0,  1'b0);
    add(1'b0, 16'h0201, 1'b0, 1'b1, 4'd0,  1'b0);
    add(1'b0, 16'h0201, 1'b1, 1'b0, 4'd0,  1'b0);
    // long hold on channel 5 with done low
    add(1'b0, 16'h0020, 1'b0, 1'b1, 4'd5,  1'b0);
`ifdef ARB_TIMEOUT_EN
    add(1'b0, 16'h0020, 1'b0, 1'b1, 4'd5,  1'b0);
    add(1'b0, 16'h0020, 1'b0, 1'b1, 4'd5,  1'b0);
    add(1'b0, 16'h0020, 1'b0, 1'b1, 4'd5,  1'b0);
    add(1'b0, 16'h0020, 1'b0, 1'b0, 4'd5,  1'b1);
    add(1'b0, 16'h0020, 1'b0, 1'b1, 4'd5,  1'b0);
    add(1'b0, 16'h0020, 1'b0, 1'b1, 4'd5,  1'b0);
    add(1'b0, 16'h0020, 1'b0, 1'b1, 4'd5,  1'b0);
    add(1'b0, 16'h0020, 1'b0, 1'b1, 4'd5,  1'b0);
    // done on the last budgeted cycle is a normal release
    add(1'b0, 16'h0020, 1'b1, 1'b0, 4'd5,  1'b0);
`else
    for (int i = 0; i < 6; i++) begin
      add(1'b0, 16'h0020, 1'b0, 1'b1, 4'd5, 1'b0);
    end
    add(1'b0, 16'h0020, 1'b1, 1'b0, 4'd5,  1'b0);
`endif
    add(1'b0, 16'h0000, 1'b0, 1'b0, 4'd5,  1'b0);

    foreach (vecs[i]) begin
      step(vecs[i].r, vecs[i].q, vecs[i].d, vecs[i].v, vecs[i].s, vecs[i].t,
           $sformatf("vec%0d", i));
    end

    // fairness: all requesting with prompt done visits 0..15 in order
    step(1'b1, 16'hFFFF, 1'b1, 1'b0, 4'd0, 1'b0, "fair_reset");
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 16'hFFFF, 1'b0, 1'b1, 4'(i), 1'b0, $sformatf("fair_grant%0d", i));
      step(1'b0, 16'hFFFF, 1'b1, 1'b0, 4'(i), 1'b0, $sformatf("fair_release%0d", i));
    end

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
